axil_master_arbiter: RTL and testbench
======================================

# axil_master_arbiter

Shares one AXI-Lite master port between up to N_REQ single-word requesters (power-sequencing writes, observation fetch reads and writes) so the power controller needs one bus master instead of separate read and write engines. Grants one requester at a time with round-robin fairness and issues exactly one read or write transaction per grant. Returns a one-cycle acknowledge carrying read data and an error flag. Only one transaction is outstanding on the bus at any time.

## Interface
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_i  in  N_REQ  level request; held high, payload stable, until ack
- we_i  in  N_REQ  1 = write, 0 = read
- addr_i  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W+:ADDR_W]
- wdata_i  in  N_REQ*DATA_W  packed write data
- ack_o  out  N_REQ  one-cycle done pulse to the granted requester
- err_o  out  1  valid with ack; 1 if resp != 2'b00
- rdata_o  out  DATA_W  read data; valid with ack of a read
- m_aw_addr/m_aw_valid out, m_aw_ready in; m_w_data/m_w_strb/m_w_valid out, m_w_ready in; m_b_resp[2]/m_b_valid in, m_b_ready out
- m_ar_addr/m_ar_valid out, m_ar_ready in; m_r_data/m_r_resp[2]/m_r_valid in, m_r_ready out

## Operation
- FSM: IDLE, ISSUE, RESP, ACK.
- IDLE: if any req_i is high, grant the first requester at or after rr_ptr, searching cyclically. Register the grant, we, addr and wdata, then go to ISSUE.
- ISSUE, write: aw_valid and w_valid rise together. m_w_strb = all ones. Each valid drops independently on its own handshake. Go to RESP once both handshakes are done; they may complete in the same cycle or in different cycles.
- ISSUE, read: ar_valid is held until ar_ready, then go to RESP.
- RESP: assert b_ready for a write or r_ready for a read; never both. On the valid/ready handshake:
  - latch rdata (reads only), zero-extended as-is
  - err = resp != 0
  - go to ACK.
- ACK: ack_o[grant] = 1 for exactly one cycle, with err_o and rdata_o. Set rr_ptr = grant+1, wrapping to 0 past N_REQ-1. Return to IDLE.
- No new grant in the ACK cycle. Requesters must drop req_i on the clock edge that ends the ack cycle.
- rdata_o and err_o hold their last value outside ACK. Only the ack cycle is meaningful.
- A request deasserted before its grant is simply skipped. Deasserting after the grant is illegal; the transaction completes regardless.

## Timing
- Reset values: all m_*_valid, m_b_ready, m_r_ready, ack_o, err_o = 0; rdata_o = 0; state IDLE; rr_ptr = 0.
- Reset mid-transaction: everything returns to reset values on the next edge. The outstanding bus transaction is abandoned and no ack is issued.
- Minimum latency with a zero-wait slave:
  - req sampled in IDLE at cycle 0
  - valids high at cycle 1 and handshake at cycle 1
  - b_ready/r_ready high at cycle 2, response at cycle 2
  - ack_o at cycle 3
  - next grant decision no earlier than cycle 4.
- Each added slave wait cycle on a handshake adds one cycle.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- AXIL_ARB_PRIO0_EN defined: requester 0 has fixed priority and wins in IDLE whenever req_i[0] = 1. The others are round-robin among themselves; rr_ptr is not updated by requester-0 grants.
- Undefined: pure round-robin across all N_REQ requesters.

## Test plan
- Single write, N_REQ=2: req_i[1], addr 0x40, data 0xA5A5_0001, zero-wait slave -> aw/w at cycle 1, b_ready at cycle 2, ack_o=2'b10 at cycle 3, err_o=0.
- Single read: req_i[0], addr 0x100, slave returns 0xDEADBEEF after 3 r wait cycles -> ack_o=2'b01 with rdata_o=0xDEADBEEF at cycle 6, err_o=0.
- Staggered handshakes: aw_ready at cycle 1, w_ready at cycle 4 -> aw_valid low from cycle 2, w_valid low from cycle 5, b_ready from cycle 5.
- Fairness, with and without macro: req_i=2'b11 held continuously by re-raising after each ack.
  - Without macro: grants alternate 0,1,0,1.
  - With AXIL_ARB_PRIO0_EN: requester 0 is granted every time.
- Error: slave b_resp=2'b10 -> ack with err_o=1. The next transaction with OKAY -> err_o=0.
- Reset mid-op: rst_n low during RESP -> next cycle all valids and readies low, no ack. The next request is granted to requester 0 (rr_ptr=0).

Source files
------------

// File: rtl/axil_master_arbiter.sv
// axil_master_arbiter: shares one AXI-Lite master port between N_REQ single-word requesters.
// Grants one requester at a time, round-robin, and runs exactly one read or write per grant.
// Only one bus transaction is outstanding; a one-cycle ack returns read data and an error flag.
// Optional macro AXIL_ARB_PRIO0_EN: requester 0 wins whenever it asks; the rest share round-robin.
module axil_master_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        we_i,
    input  logic [N_REQ*ADDR_W-1:0] addr_i,
    input  logic [N_REQ*DATA_W-1:0] wdata_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic                    err_o,
    output logic [DATA_W-1:0]       rdata_o,
    output logic [ADDR_W-1:0]       m_aw_addr,
    output logic                    m_aw_valid,
    input  logic                    m_aw_ready,
    output logic [DATA_W-1:0]       m_w_data,
    output logic [DATA_W/8-1:0]     m_w_strb,
    output logic                    m_w_valid,
    input  logic                    m_w_ready,
    input  logic [1:0]              m_b_resp,
    input  logic                    m_b_valid,
    output logic                    m_b_ready,
    output logic [ADDR_W-1:0]       m_ar_addr,
    output logic                    m_ar_valid,
    input  logic                    m_ar_ready,
    input  logic [DATA_W-1:0]       m_r_data,
    input  logic [1:0]              m_r_resp,
    input  logic                    m_r_valid,
    output logic                    m_r_ready
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_ACK} state_t;

    state_t              r_state, w_next;
    logic [PW-1:0]       r_grant, r_rr_ptr, w_sel;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_aw_valid, r_w_valid, r_ar_valid, r_b_ready, r_r_ready;
    logic [N_REQ-1:0]    r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_aw_valid_nxt, w_w_valid_nxt, w_ar_valid_nxt, w_b_ready_nxt, w_r_ready_nxt;
    logic [N_REQ-1:0]    w_ack_nxt;
    logic                w_err_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic                w_issue_done, w_resp_done, w_rr_upd;
    logic [ADDR_W-1:0]   w_addr  [N_REQ];
    logic [DATA_W-1:0]   w_wdata [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr[g]  = addr_i[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = wdata_i[g*DATA_W +: DATA_W];
    end

    // A write is issued once both address and data handshakes have happened, in any order
    assign w_issue_done = r_we ? ~(r_aw_valid & ~m_aw_ready) & ~(r_w_valid & ~m_w_ready)
                               : r_ar_valid & m_ar_ready;
    assign w_resp_done  = r_we ? r_b_ready & m_b_valid : r_r_ready & m_r_valid;

`ifdef AXIL_ARB_PRIO0_EN
    assign w_rr_upd = r_grant != '0;
`else
    assign w_rr_upd = 1'b1;
`endif

    // Cyclic search: lowest requester at/after the pointer, else lowest overall (wrap-around)
    always_comb begin
        w_sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (req_i[i]) w_sel = PW'(i);
        for (int i = N_REQ - 1; i >= 0; i--) if (req_i[i] && PW'(i) >= r_rr_ptr) w_sel = PW'(i);
`ifdef AXIL_ARB_PRIO0_EN
        if (req_i[0]) w_sel = '0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; ACK always returns to IDLE so no grant is made in the ack cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = |req_i ? S_ISSUE : S_IDLE;
            S_ISSUE: w_next = w_issue_done ? S_RESP : S_ISSUE;
            S_RESP:  w_next = w_resp_done ? S_ACK : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values for the registered bus and requester outputs
    always_comb begin
        w_aw_valid_nxt = r_aw_valid;
        w_w_valid_nxt  = r_w_valid;
        w_ar_valid_nxt = r_ar_valid;
        w_b_ready_nxt  = r_b_ready;
        w_r_ready_nxt  = r_r_ready;
        w_ack_nxt      = '0;
        w_err_nxt      = r_err;
        w_rdata_nxt    = r_rdata;
        case (r_state)
            S_IDLE: begin
                w_aw_valid_nxt = |req_i & we_i[w_sel];
                w_w_valid_nxt  = |req_i & we_i[w_sel];
                w_ar_valid_nxt = |req_i & ~we_i[w_sel];
            end
            S_ISSUE: begin
                w_aw_valid_nxt = r_aw_valid & ~m_aw_ready;
                w_w_valid_nxt  = r_w_valid & ~m_w_ready;
                w_ar_valid_nxt = r_ar_valid & ~m_ar_ready;
                w_b_ready_nxt  = w_issue_done & r_we;
                w_r_ready_nxt  = w_issue_done & ~r_we;
            end
            S_RESP: if (w_resp_done) begin
                w_b_ready_nxt      = 1'b0;
                w_r_ready_nxt      = 1'b0;
                w_ack_nxt[r_grant] = 1'b1;
                w_err_nxt          = r_we ? |m_b_resp : |m_r_resp;
                w_rdata_nxt        = r_we ? r_rdata : m_r_data;
            end
            default: ;
        endcase
    end

    // Output registers, grant capture and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_b_ready  <= 1'b0;
            r_r_ready  <= 1'b0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_grant    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rr_ptr   <= '0;
        end else begin
            r_aw_valid <= w_aw_valid_nxt;
            r_w_valid  <= w_w_valid_nxt;
            r_ar_valid <= w_ar_valid_nxt;
            r_b_ready  <= w_b_ready_nxt;
            r_r_ready  <= w_r_ready_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
            if (r_state == S_IDLE && |req_i) begin
                r_grant <= w_sel;
                r_we    <= we_i[w_sel];
                r_addr  <= w_addr[w_sel];
                r_wdata <= w_wdata[w_sel];
            end
            if (r_state == S_ACK && w_rr_upd)
                r_rr_ptr <= (r_grant == PW'(N_REQ - 1)) ? '0 : r_grant + PW'(1);
        end
    end

    assign ack_o      = r_ack;
    assign err_o      = r_err;
    assign rdata_o    = r_rdata;
    assign m_aw_addr  = r_addr;
    assign m_aw_valid = r_aw_valid;
    assign m_w_data   = r_wdata;
    assign m_w_strb   = '1;
    assign m_w_valid  = r_w_valid;
    assign m_b_ready  = r_b_ready;
    assign m_ar_addr  = r_addr;
    assign m_ar_valid = r_ar_valid;
    assign m_r_ready  = r_r_ready;
endmodule

// File: tb/tb_axil_master_arbiter.sv
// tb_axil_master_arbiter: directed vector table plus hand sequences for axil_master_arbiter (N_REQ=2).
module tb_axil_master_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i, we_i, ack_o;
    logic [63:0] addr_i, wdata_i;
    logic        err_o;
    logic [31:0] rdata_o, m_aw_addr, m_w_data, m_ar_addr, m_r_data;
    logic [3:0]  m_w_strb;
    logic        m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_b_valid, m_b_ready;
    logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [1:0]  m_b_resp, m_r_resp;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          aw_w;
        int          w_w;
        int          ar_w;
        int          rsp_w;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  exp_ack;
        int          exp_cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t tbl [6];

    axil_master_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
        .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
        .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic slave_idle();
        m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0;
        m_b_valid = 0; m_r_valid = 0; m_b_resp = 0; m_r_resp = 0; m_r_data = 0;
    endtask

    // Presents one request at the current (IDLE) cycle and plays a slave with the given wait counts
    task automatic run_vec(input vec_t v, input string nm);
        int cyc = 0, awc = 0, wc = 0, arc = 0, bc = 0, rc = 0;
        bit done = 0, both = 0;
        logic [31:0] s_addr = 0, s_wdata = 0;
        logic [3:0]  s_strb = 0;
        req_i = v.req; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata;
        while (!done && cyc < 40) begin
            m_aw_ready = m_aw_valid && awc >= v.aw_w;
            if (m_aw_valid) awc++;
            if (m_aw_ready) s_addr = m_aw_addr;
            m_w_ready = m_w_valid && wc >= v.w_w;
            if (m_w_valid) wc++;
            if (m_w_ready) begin s_wdata = m_w_data; s_strb = m_w_strb; end
            m_ar_ready = m_ar_valid && arc >= v.ar_w;
            if (m_ar_valid) arc++;
            if (m_ar_ready) s_addr = m_ar_addr;
            m_b_valid = m_b_ready && bc >= v.rsp_w;
            if (m_b_ready) bc++;
            m_r_valid = m_r_ready && rc >= v.rsp_w;
            if (m_r_ready) rc++;
            m_b_resp = v.resp; m_r_resp = v.resp; m_r_data = v.rdata;
            if (m_b_ready && m_r_ready) both = 1;
            if (ack_o != 0) done = 1;
            else begin tick(); cyc++; end
        end
        chk({nm, " ack seen"}, 64'(done), 1);
        chk({nm, " ack cycle"}, 64'(cyc), 64'(v.exp_cyc));
        chk({nm, " ack_o"}, 64'(ack_o), 64'(v.exp_ack));
        chk({nm, " err_o"}, 64'(err_o), 64'(v.exp_err));
        chk({nm, " rdata_o"}, 64'(rdata_o), 64'(v.exp_rdata));
        chk({nm, " bus addr"}, 64'(s_addr), 64'(v.exp_addr));
        chk({nm, " b/r ready exclusive"}, 64'(both), 0);
        if (v.we != 0) begin
            chk({nm, " bus wdata"}, 64'(s_wdata), 64'(v.exp_wdata));
            chk({nm, " bus strb"}, 64'(s_strb), 64'hF);
        end
        slave_idle();
        tick();
        req_i = '0;
        chk({nm, " ack one cycle"}, 64'(ack_o), 0);
        chk({nm, " err hold"}, 64'(err_o), 64'(v.exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t fv;
        logic [1:0] g;
        tbl[0] = '{2'b10, 2'b10, {32'h40, 32'hFFFF_FFF0}, {32'hA5A5_0001, 32'h1111_1111},
                   0, 0, 0, 0, 2'b00, 32'h0, 2'b10, 3, 1'b0, 32'h0, 32'h40, 32'hA5A5_0001};
        tbl[1] = '{2'b01, 2'b00, {32'hFFFF_FFF4, 32'h100}, {32'h2222_2222, 32'h3333_3333},
                   0, 0, 0, 3, 2'b00, 32'hDEAD_BEEF, 2'b01, 6, 1'b0, 32'hDEAD_BEEF, 32'h100, 32'h0};
        tbl[2] = '{2'b01, 2'b01, {32'hFFFF_FFF8, 32'h8}, {32'h4444_4444, 32'h1234_5678},
                   2, 0, 0, 1, 2'b10, 32'h0, 2'b01, 6, 1'b1, 32'hDEAD_BEEF, 32'h8, 32'h1234_5678};
        tbl[3] = '{2'b10, 2'b10, {32'h44, 32'hFFFF_FFFC}, {32'hCAFE_F00D, 32'h5555_5555},
                   0, 1, 0, 0, 2'b00, 32'h0, 2'b10, 4, 1'b0, 32'hDEAD_BEEF, 32'h44, 32'hCAFE_F00D};
        tbl[4] = '{2'b10, 2'b00, {32'h200, 32'hFFFF_FFEC}, {32'h6666_6666, 32'h7777_7777},
                   0, 0, 1, 0, 2'b11, 32'h0BAD_F00D, 2'b10, 4, 1'b1, 32'h0BAD_F00D, 32'h200, 32'h0};
        tbl[5] = '{2'b01, 2'b00, {32'hFFFF_FFE8, 32'h300}, {32'h8888_8888, 32'h9999_9999},
                   0, 0, 0, 0, 2'b00, 32'h0000_0001, 2'b01, 3, 1'b0, 32'h0000_0001, 32'h300, 32'h0};

        rst_n = 0; req_i = 0; we_i = 0; addr_i = 0; wdata_i = 0;
        slave_idle();
        repeat (3) tick();
        chk("reset ack_o", 64'(ack_o), 0);
        chk("reset err_o", 64'(err_o), 0);
        chk("reset rdata_o", 64'(rdata_o), 0);
        chk("reset valids", 64'({m_aw_valid, m_w_valid, m_ar_valid}), 0);
        chk("reset readies", 64'({m_b_ready, m_r_ready}), 0);
        rst_n = 1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Staggered write handshakes: aw at cycle 1, w at cycle 4
        req_i = 2'b01; we_i = 2'b01; addr_i = {32'h0, 32'h10}; wdata_i = {32'h0, 32'h77};
        tick();
        chk("stg c1 aw_valid", 64'(m_aw_valid), 1);
        chk("stg c1 w_valid", 64'(m_w_valid), 1);
        m_aw_ready = 1;
        tick();
        chk("stg c2 aw_valid", 64'(m_aw_valid), 0);
        chk("stg c2 w_valid", 64'(m_w_valid), 1);
        m_aw_ready = 0;
        tick();
        chk("stg c3 w_valid", 64'(m_w_valid), 1);
        chk("stg c3 b_ready", 64'(m_b_ready), 0);
        tick();
        chk("stg c4 w_valid", 64'(m_w_valid), 1);
        m_w_ready = 1;
        tick();
        chk("stg c5 w_valid", 64'(m_w_valid), 0);
        chk("stg c5 b_ready", 64'(m_b_ready), 1);
        chk("stg c5 r_ready", 64'(m_r_ready), 0);
        m_w_ready = 0; m_b_valid = 1; m_b_resp = 2'b00;
        tick();
        chk("stg c6 ack_o", 64'(ack_o), 2'b01);
        chk("stg c6 err_o", 64'(err_o), 0);
        chk("stg c6 b_ready", 64'(m_b_ready), 0);
        m_b_valid = 0;
        tick();
        req_i = 0;
        chk("stg c7 ack_o", 64'(ack_o), 0);

        // Reset during RESP of a requester-1 write; pointer was 1 before the reset
        req_i = 2'b10; we_i = 2'b10; addr_i = {32'h50, 32'h60}; wdata_i = {32'hAB, 32'hCD};
        tick();
        chk("rst c1 aw_valid", 64'(m_aw_valid), 1);
        m_aw_ready = 1; m_w_ready = 1;
        tick();
        chk("rst c2 b_ready", 64'(m_b_ready), 1);
        m_aw_ready = 0; m_w_ready = 0; rst_n = 0;
        tick();
        chk("rst c3 valids/readies", 64'({m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready}), 0);
        chk("rst c3 ack_o", 64'(ack_o), 0);
        rst_n = 1; req_i = 0;
        tick();
        chk("rst c4 ack_o", 64'(ack_o), 0);

        // Both requesters held high; first grant after reset must go to requester 0
        for (int i = 0; i < 4; i++) begin
`ifdef AXIL_ARB_PRIO0_EN
            g = 2'b01;
`else
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
            fv = '{2'b11, 2'b11, {32'h1000, 32'h2000}, {32'hB1, 32'hB0},
                   0, 0, 0, 0, 2'b00, 32'h0, g, 3, 1'b0, 32'h0,
                   (g == 2'b01) ? 32'h2000 : 32'h1000, (g == 2'b01) ? 32'hB0 : 32'hB1};
            run_vec(fv, $sformatf("fair%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
